cmp_flag_tracker: RTL and testbench
===================================

# cmp_flag_tracker

Consumes the registered `greater`/`lesser`/`equal` flags of the 16-bit threshold comparator and turns them into a debounced level state with crossing events. Each flag sample must persist before the state changes. The block emits one-cycle crossing pulses, keeps saturating crossing counters and flags protocol violations (flags not one-hot). It sits directly downstream of the comparator, on the same clock, and feeds status/alarm logic.

## Interface
- `DEBOUNCE`, 3: consecutive valid identical samples required to change state; legal range 1..15.
- `CNT_W`, 8: width of each crossing counter.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `flag_valid` in 1: the comparator flags are a valid sample this cycle.
- `greater` in 1: comparator flag, in > thresh.
- `lesser` in 1: comparator flag, in < thresh.
- `equal` in 1: comparator flag, in == thresh.
- `clr_counts` in 1: synchronous clear of both counters and `flag_err`.
- `state` out 2: debounced level. 00 UNKNOWN, 01 BELOW, 10 AT, 11 ABOVE.
- `rise_pulse` out 1: one-cycle pulse on entry to ABOVE from BELOW or AT.
- `fall_pulse` out 1: one-cycle pulse on entry to BELOW from AT or ABOVE.
- `rise_count` out CNT_W: number of `rise_pulse` events, saturating.
- `fall_count` out CNT_W: number of `fall_pulse` events, saturating.
- `flag_err` out 1: sticky; set by any valid sample whose flags are not one-hot.

## Operation
- **Reset values:** `state`=UNKNOWN, pulses=0, counts=0, `flag_err`=0. Internal candidate=UNKNOWN, run counter=0.
- **Sample decode:** applies only when `flag_valid`=1 and exactly one flag is set.
  - `lesser` -> BELOW.
  - `equal` -> AT.
  - `greater` -> ABOVE.
- **Invalid sample** (`flag_valid`=1, flags not one-hot, including all-zero):
  - `flag_err` is set.
  - The run counter clears to 0.
  - `state` is unchanged.
- **`flag_valid`=0:** nothing changes, and the run counter holds. Gaps do not break a run.
- **Run tracking:**
  - A decoded sample equal to `state` clears the run to 0.
  - A decoded sample differing from `state` and equal to the candidate increments the run.
  - A decoded sample differing from `state` and from the candidate sets the candidate to the sample and sets the run to 1.
- **State change:** when the run reaches `DEBOUNCE` on a valid sample, in the same edge:
  - `state` takes the candidate value.
  - The run clears to 0.
  - The applicable pulse asserts for exactly one cycle.
- **UNKNOWN exits:** leaving UNKNOWN never pulses. UNKNOWN is re-entered only by reset.
- **Direct jumps:** BELOW<->ABOVE pulses normally. AT->ABOVE is a rise and AT->BELOW is a fall. Entering AT never pulses.
- **Counters:**
  - Each increments on its pulse.
  - Each saturates at 2^CNT_W-1 and holds, with no wrap.
- **`clr_counts`:**
  - Zeroes both counters and `flag_err` at the next edge.
  - If it coincides with a pulse or invalid sample, the clear wins: the count reads 0 and `flag_err` reads 0.
  - The pulse itself still asserts.
  - `state` and the run are unaffected.
- **Reset mid-run:** asynchronous return to the reset values. A partial run is discarded.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: with `DEBOUNCE`=N and consecutive valid samples on cycles k..k+N-1, `state` and the pulse are visible from cycle k+N.
- `DEBOUNCE`=1 gives a one-cycle latency from the sample to `state`.
- A pulse is high for one cycle only.
- The counter updates in the same edge as its pulse, so the new count is visible together with the pulse.
- `flag_err` is visible from the cycle after the offending sample.
- Reset assertion forces the outputs without waiting for a clock edge. After deassertion, the first edge samples normally.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` mid-cycle, then release.
  - Required: `state`=00, counts 0, `flag_err` 0 immediately; 3 valid `lesser` samples -> `state`=01 on the 4th cycle, no `fall_pulse`.
- **Debounce:**
  - Stimulus: from BELOW (`DEBOUNCE`=3), sequence `greater`, `greater`, `lesser`, `greater`, `greater`, `greater`.
  - Required: no change until after the final three `greater` samples; then `state`=11, a single `rise_pulse`, `rise_count`=1.
- **Gaps and AT:**
  - Stimulus: from ABOVE, `equal`, `flag_valid`=0 for 2 cycles, `equal`, `equal`.
  - Required: `state`=10 with no pulse; then 3 `lesser` samples -> `fall_pulse`, `fall_count`=1.
- **Error:**
  - Stimulus: flags 3'b110 with `flag_valid`=1 during a run of 2 `greater` samples.
  - Required: `flag_err`=1; the run is reset, so 3 more `greater` samples are needed to reach ABOVE.
- **Saturation/clear:**
  - Stimulus (`CNT_W`=2): 5 rise events; then `clr_counts` coincident with a 6th rise.
  - Required: `rise_count`=3 after the 3rd and every later event; after the clear, `rise_count`=0 while `rise_pulse`=1 in that cycle.

Source files
------------

// File: rtl/cmp_flag_tracker.sv
// Debounces the comparator's one-hot greater/lesser/equal flags into a level state,
// emitting crossing pulses, saturating crossing counters and a sticky protocol-error flag.
module cmp_flag_tracker #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_valid,
  input  logic             greater,
  input  logic             lesser,
  input  logic             equal,
  input  logic             clr_counts,
  output logic [1:0]       state,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] fall_count,
  output logic             flag_err
);

  typedef enum logic [1:0] {
    StUnknown = 2'b00,
    StBelow   = 2'b01,
    StAt      = 2'b10,
    StAbove   = 2'b11
  } level_e;

  localparam logic [3:0]       RunTarget = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  level_e           state_q, state_d;
  level_e           cand_q, cand_d;
  level_e           samp;
  logic [3:0]       run_q, run_d, run_inc;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic             err_q, err_d;
  logic             one_hot;
  logic             samp_ok;
  logic             samp_bad;

  // Sample decode; samp is only meaningful when samp_ok is set.
  always_comb begin
    one_hot  = ({greater, lesser, equal} == 3'b100) ||
               ({greater, lesser, equal} == 3'b010) ||
               ({greater, lesser, equal} == 3'b001);
    samp_ok  = flag_valid && one_hot;
    samp_bad = flag_valid && !one_hot;
    if (lesser) begin
      samp = StBelow;
    end else if (equal) begin
      samp = StAt;
    end else if (greater) begin
      samp = StAbove;
    end else begin
      samp = StUnknown;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    run_inc = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (samp_bad) begin
      run_d = '0;
    end else if (samp_ok) begin
      if (samp == state_q) begin
        run_d = '0;
      end else begin
        if (samp == cand_q) begin
          run_inc = run_q + 4'd1;
        end else begin
          cand_d  = samp;
          run_inc = 4'd1;
        end
        if (run_inc == RunTarget) begin
          state_d = cand_d;
          run_d   = '0;
          // Leaving UNKNOWN or entering AT never pulses.
          rise_d  = (cand_d == StAbove) && ((state_q == StBelow) || (state_q == StAt));
          fall_d  = (cand_d == StBelow) && ((state_q == StAt) || (state_q == StAbove));
        end else begin
          run_d = run_inc;
        end
      end
    end
  end

  // Clear takes priority over a coincident increment or error.
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    err_d      = err_q;
    if (clr_counts) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      if (rise_d && (rise_cnt_q != CntMax)) begin
        rise_cnt_d = rise_cnt_q + 1'b1;
      end
      if (fall_d && (fall_cnt_q != CntMax)) begin
        fall_cnt_d = fall_cnt_q + 1'b1;
      end
      if (samp_bad) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StUnknown;
      cand_q     <= StUnknown;
      run_q      <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      run_q      <= run_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      err_q      <= err_d;
    end
  end

  assign state      = state_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign rise_count = rise_cnt_q;
  assign fall_count = fall_cnt_q;
  assign flag_err   = err_q;

endmodule

// File: tb/tb_cmp_flag_tracker.sv
// Bench for cmp_flag_tracker: two instances (DEBOUNCE=3/CNT_W=8 and DEBOUNCE=1/CNT_W=2)
// share stimulus; a sample-history reference model checks every cycle.
module tb_cmp_flag_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_valid = 1'b0;
  logic greater = 1'b0;
  logic lesser = 1'b0;
  logic equal = 1'b0;
  logic clr_counts = 1'b0;

  logic [1:0] a_state, b_state;
  logic       a_rise, a_fall, a_err, b_rise, b_fall, b_err;
  logic [7:0] a_rc, a_fc;
  logic [1:0] b_rc, b_fc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmp_flag_tracker #(.DEBOUNCE(3), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .flag_valid(flag_valid), .greater(greater), .lesser(lesser),
    .equal(equal), .clr_counts(clr_counts), .state(a_state), .rise_pulse(a_rise),
    .fall_pulse(a_fall), .rise_count(a_rc), .fall_count(a_fc), .flag_err(a_err)
  );

  cmp_flag_tracker #(.DEBOUNCE(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .flag_valid(flag_valid), .greater(greater), .lesser(lesser),
    .equal(equal), .clr_counts(clr_counts), .state(b_state), .rise_pulse(b_rise),
    .fall_pulse(b_fall), .rise_count(b_rc), .fall_count(b_fc), .flag_err(b_err)
  );

  // Reference model: history of decoded samples since the last break (state change,
  // same-as-state sample, invalid sample); the state moves once the last DEBOUNCE
  // entries all agree on a level different from the current one.
  int         db[2]   = '{3, 1};
  int         maxc[2] = '{255, 3};
  logic [1:0] m_state[2];
  bit         m_rise[2], m_fall[2], m_err[2];
  int         m_rn[2], m_fn[2];
  logic [1:0] hist[2][32];
  int         hlen[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 2'b00; m_rise[i] = 0; m_fall[i] = 0; m_err[i] = 0;
      m_rn[i] = 0; m_fn[i] = 0; hlen[i] = 0;
    end
  endtask

  function automatic int trailing(int i, logic [1:0] s);
    int n = 0;
    for (int k = hlen[i] - 1; k >= 0; k--) begin
      if (hist[i][k] != s) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step();
    int         ones;
    logic [1:0] s, prev;
    ones = int'(greater) + int'(lesser) + int'(equal);
    s = lesser ? 2'b01 : (equal ? 2'b10 : 2'b11);
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (flag_valid) begin
        if (ones != 1) begin
          m_err[i] = 1;
          hlen[i] = 0;
        end else if (s == m_state[i]) begin
          hlen[i] = 0;
        end else begin
          if (hlen[i] == 32) begin
            for (int k = 0; k < 31; k++) hist[i][k] = hist[i][k+1];
            hlen[i] = 31;
          end
          hist[i][hlen[i]] = s;
          hlen[i]++;
          if (trailing(i, s) >= db[i]) begin
            prev = m_state[i];
            m_state[i] = s;
            hlen[i] = 0;
            m_rise[i] = (s == 2'b11) && (prev == 2'b01 || prev == 2'b10);
            m_fall[i] = (s == 2'b01) && (prev == 2'b10 || prev == 2'b11);
            if (m_rise[i]) m_rn[i]++;
            if (m_fall[i]) m_fn[i]++;
          end
        end
      end
      if (clr_counts) begin
        m_rn[i] = 0; m_fn[i] = 0; m_err[i] = 0;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic check_all();
    check("a_state", 32'(a_state), 32'(m_state[0]));
    check("a_rise", 32'(a_rise), 32'(m_rise[0]));
    check("a_fall", 32'(a_fall), 32'(m_fall[0]));
    check("a_rise_count", 32'(a_rc), 32'(sat(m_rn[0], maxc[0])));
    check("a_fall_count", 32'(a_fc), 32'(sat(m_fn[0], maxc[0])));
    check("a_flag_err", 32'(a_err), 32'(m_err[0]));
    check("b_state", 32'(b_state), 32'(m_state[1]));
    check("b_rise", 32'(b_rise), 32'(m_rise[1]));
    check("b_fall", 32'(b_fall), 32'(m_fall[1]));
    check("b_rise_count", 32'(b_rc), 32'(sat(m_rn[1], maxc[1])));
    check("b_fall_count", 32'(b_fc), 32'(sat(m_fn[1], maxc[1])));
    check("b_flag_err", 32'(b_err), 32'(m_err[1]));
  endtask

  // Inputs stay stable from 1 time unit after an edge until the next edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(bit v, bit g, bit l, bit e);
    flag_valid = v; greater = g; lesser = l; equal = e;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit       v, g, l, e;
    bit [1:0] st;
    bit       r, f, err;
  } vec_t;

  function automatic vec_t mk(bit v, bit g, bit l, bit e, bit [1:0] st, bit r, bit f, bit err);
    vec_t x;
    x.v = v; x.g = g; x.l = l; x.e = e; x.st = st; x.r = r; x.f = f; x.err = err;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [2:0] bad_flags[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [2:0] bf;
    int         lvl, r;

    // Expected values for u_a (DEBOUNCE=3), derived by hand from reset.
    tbl.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b11, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b11, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b10, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2'b10, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2'b10, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2'b01, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b01, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 2'b11, 1, 0, 1));

    model_reset();
    #12 rst = 1'b0;
    check_all();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].g, tbl[i].l, tbl[i].e);
      tick();
      check($sformatf("tbl%0d_state", i), 32'(a_state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_rise", i), 32'(a_rise), 32'(tbl[i].r));
      check($sformatf("tbl%0d_fall", i), 32'(a_fall), 32'(tbl[i].f));
      check($sformatf("tbl%0d_err", i), 32'(a_err), 32'(tbl[i].err));
    end
    check("tbl_rise_count", 32'(a_rc), 32'd2);
    check("tbl_fall_count", 32'(a_fc), 32'd1);

    // Mid-cycle reset from ABOVE with nonzero counts and error set.
    drive(0, 0, 0, 0);
    async_reset();
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_rise_count", 32'(a_rc), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    drive(1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_l%0d_state", k), 32'(a_state), (k == 2) ? 32'd1 : 32'd0);
      check($sformatf("rst_l%0d_fall", k), 32'(a_fall), 32'd0);
    end

    // Saturation on u_b (CNT_W=2): alternate ABOVE/BELOW with DEBOUNCE=1.
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 0, 0);
      tick();
      check($sformatf("sat%0d_rise", k), 32'(b_rise), 32'd1);
      check($sformatf("sat%0d_count", k), 32'(b_rc), (k < 3) ? 32'(k) : 32'd3);
      drive(1, 0, 1, 0);
      tick();
    end
    drive(1, 1, 0, 0);
    clr_counts = 1'b1;
    tick();
    check("clr_rise", 32'(b_rise), 32'd1);
    check("clr_count", 32'(b_rc), 32'd0);
    clr_counts = 1'b0;

    // Randomized phase: sticky level with occasional gaps, bad flags, clears, resets.
    lvl = 1;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        drive(0, 1'($urandom), 1'($urandom), 1'($urandom));
      end else if (r < 20) begin
        bf = bad_flags[$urandom_range(0, 4)];
        drive(1, bf[2], bf[1], bf[0]);
      end else begin
        if ($urandom_range(0, 3) == 0) lvl = int'($urandom_range(1, 3));
        drive(1, lvl == 3, lvl == 1, lvl == 2);
      end
      clr_counts = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
